// File: rtl/sma_pkg.sv
// Shared types and constants for the moving-average level detector slice.
package sma_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DWELL_MAX  = 15;
    localparam int CNT_W      = 4;
    localparam int EPI_W      = 16;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_ARM_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_ARM_LO = 2'd3
    } state_e;

endpackage

// File: rtl/sma_level_detector_if.sv
// Sample/threshold inputs and detector outputs bundled between the filter side and the detector.
interface sma_level_detector_if #(parameter int DATA_W = 16);

    logic                     en;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] thr_hi;
    logic signed [DATA_W-1:0] thr_lo;
    logic                     level;
    logic                     rise;
    logic                     fall;
    logic signed [DATA_W-1:0] peak;
    logic                     peak_valid;
    logic [15:0]              episodes;
    logic                     cfg_err;

    modport master (
        output en, x, thr_hi, thr_lo,
        input  level, rise, fall, peak, peak_valid, episodes, cfg_err
    );

    modport slave (
        input  en, x, thr_hi, thr_lo,
        output level, rise, fall, peak, peak_valid, episodes, cfg_err
    );

endinterface

// File: rtl/sma_peak_track.sv
// Running signed maximum of an episode; cand is the maximum including the current sample.
module sma_peak_track #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     upd,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] cand
);

    logic signed [DATA_W-1:0] max_r;

    assign cand = (d > max_r) ? d : max_r;

    // Tracker register: clear wins over load, load wins over update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            max_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            max_r <= {DATA_W{1'b0}};
        end else if (load) begin
            max_r <= d;
        end else if (upd) begin
            max_r <= cand;
        end else begin
            max_r <= max_r;
        end
    end

endmodule

// File: rtl/sma_level_detector.sv
// Hysteresis level detector with dwell qualification, peak reporting and episode counting.
module sma_level_detector
    import sma_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DWELL  = 3
) (
    input logic               clk,
    input logic               rst,
    sma_level_detector_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);

    state_e                   state_r, state_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s, cnt_inc_s;
    logic                     hi_q_s, lo_q_s, cfg_bad_s;
    logic                     rise_s, fall_s;
    logic                     trk_clr_s, trk_load_s, trk_upd_s;
    logic signed [DATA_W-1:0] trk_cand_s;
    logic                     level_r, rise_r, fall_r, peak_valid_r, cfg_err_r;
    logic signed [DATA_W-1:0] peak_r;
    logic [EPI_W-1:0]         episodes_r;

    assign hi_q_s    = (bus.x >= bus.thr_hi);
    assign lo_q_s    = (bus.x <= bus.thr_lo);
    assign cfg_bad_s = (bus.thr_hi <= bus.thr_lo);
    assign cnt_inc_s = cnt_r + CNT_ONE;

    sma_peak_track #(.DATA_W(DATA_W)) u_peak (
        .clk  (clk),
        .rst  (rst),
        .clr  (trk_clr_s),
        .load (trk_load_s),
        .upd  (trk_upd_s),
        .d    (bus.x),
        .cand (trk_cand_s)
    );

    // Next-state, dwell counter and tracker control decisions for the current edge.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        trk_clr_s   = 1'b0;
        trk_load_s  = 1'b0;
        trk_upd_s   = 1'b0;
        if (cfg_bad_s) begin
            state_nxt_s = ST_LOW;
            cnt_nxt_s   = CNT_ZERO;
            trk_clr_s   = 1'b1;
        end else if (bus.en) begin
            case (state_r)
                ST_LOW: begin
                    if (hi_q_s) begin
                        trk_load_s = 1'b1;
                        if (DWELL_C == CNT_ONE) begin
                            state_nxt_s = ST_HIGH;
                            cnt_nxt_s   = CNT_ZERO;
                            rise_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARM_HI;
                            cnt_nxt_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                ST_ARM_HI: begin
                    if (!hi_q_s) begin
                        state_nxt_s = ST_LOW;
                        cnt_nxt_s   = CNT_ZERO;
                        trk_clr_s   = 1'b1;
                    end else if (cnt_inc_s == DWELL_C) begin
                        trk_upd_s   = 1'b1;
                        state_nxt_s = ST_HIGH;
                        cnt_nxt_s   = CNT_ZERO;
                        rise_s      = 1'b1;
                    end else begin
                        trk_upd_s = 1'b1;
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_HIGH: begin
                    trk_upd_s = 1'b1;
                    if (lo_q_s && (DWELL_C == CNT_ONE)) begin
                        state_nxt_s = ST_LOW;
                        cnt_nxt_s   = CNT_ZERO;
                        fall_s      = 1'b1;
                    end else if (lo_q_s) begin
                        state_nxt_s = ST_ARM_LO;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s = CNT_ZERO;
                    end
                end
                ST_ARM_LO: begin
                    trk_upd_s = 1'b1;
                    if (!lo_q_s) begin
                        state_nxt_s = ST_HIGH;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_inc_s == DWELL_C) begin
                        state_nxt_s = ST_LOW;
                        cnt_nxt_s   = CNT_ZERO;
                        fall_s      = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                    trk_clr_s   = 1'b1;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and all registered outputs; peak latches the maximum including the closing sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_LOW;
            cnt_r        <= CNT_ZERO;
            level_r      <= 1'b0;
            rise_r       <= 1'b0;
            fall_r       <= 1'b0;
            peak_valid_r <= 1'b0;
            peak_r       <= {DATA_W{1'b0}};
            episodes_r   <= {EPI_W{1'b0}};
            cfg_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            level_r      <= (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_ARM_LO);
            rise_r       <= rise_s;
            fall_r       <= fall_s;
            peak_valid_r <= fall_s;
            cfg_err_r    <= cfg_bad_s;
            if (fall_s) begin
                peak_r <= trk_cand_s;
            end else begin
                peak_r <= peak_r;
            end
            if (rise_s && (episodes_r != 16'hFFFF)) begin
                episodes_r <= episodes_r + 16'd1;
            end else begin
                episodes_r <= episodes_r;
            end
        end
    end

    assign bus.level      = level_r;
    assign bus.rise       = rise_r;
    assign bus.fall       = fall_r;
    assign bus.peak       = peak_r;
    assign bus.peak_valid = peak_valid_r;
    assign bus.episodes   = episodes_r;
    assign bus.cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_sma_level_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a run-length reference model.
module tb_sma_level_detector;

    localparam int DWELL = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sma_level_detector_if #(.DATA_W(16)) bus ();

    sma_level_detector #(.DATA_W(16), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: confirmed level plus length of the current qualifying run.
    int m_level, m_run, m_max, m_peak, m_episodes, m_rise, m_fall, m_pv, m_cfg;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int xv, input int hv, input int lv);
        m_rise = 0;
        m_fall = 0;
        m_pv   = 0;
        if (!r) begin
            m_level = 0; m_run = 0; m_max = 0; m_peak = 0; m_episodes = 0; m_cfg = 0;
        end else begin
            m_cfg = (hv <= lv) ? 1 : 0;
            if (m_cfg == 1) begin
                m_level = 0;
                m_run   = 0;
                m_max   = 0;
            end else if (e) begin
                if (m_level == 0) begin
                    if (xv >= hv) begin
                        m_max = (m_run == 0 || xv > m_max) ? xv : m_max;
                        m_run++;
                        if (m_run == DWELL) begin
                            m_level = 1;
                            m_run   = 0;
                            m_rise  = 1;
                            if (m_episodes < 65535) m_episodes++;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (xv > m_max) m_max = xv;
                    if (xv <= lv) begin
                        m_run++;
                        if (m_run == DWELL) begin
                            m_level = 0;
                            m_run   = 0;
                            m_fall  = 1;
                            m_pv    = 1;
                            m_peak  = m_max;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model, compare every output after the edge.
    task automatic step(input bit r, input bit e, input int xv, input int hv, input int lv);
        rst        = r;
        bus.en     = e;
        bus.x      = 16'(xv);
        bus.thr_hi = 16'(hv);
        bus.thr_lo = 16'(lv);
        @(posedge clk);
        model_edge(r, e, xv, hv, lv);
        #1;
        check_val("level",      int'(bus.level),      m_level);
        check_val("rise",       int'(bus.rise),       m_rise);
        check_val("fall",       int'(bus.fall),       m_fall);
        check_val("peak_valid", int'(bus.peak_valid), m_pv);
        check_val("peak",       int'(bus.peak),       m_peak);
        check_val("episodes",   int'(bus.episodes),   m_episodes);
        check_val("cfg_err",    int'(bus.cfg_err),    m_cfg);
    endtask

    task automatic run_n(input int n, input int xv);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, xv, 1000, 500);
    endtask

    initial begin
        int clean_x[7];
        int chat_x[6];
        int falls;
        int region;
        int xv, hv, lv;
        bit ev, rv;

        clk = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        m_level = 0; m_run = 0; m_max = 0; m_peak = 0; m_episodes = 0;
        m_rise = 0; m_fall = 0; m_pv = 0; m_cfg = 0;
        rst = 1'b0; bus.en = 1'b1; bus.x = 16'sd0; bus.thr_hi = 16'sd1000; bus.thr_lo = 16'sd500;

        // Reset held two edges with a qualifying sample, then rise on the third qualifying edge.
        step(1'b0, 1'b1, 2000, 1000, 500);
        step(1'b0, 1'b1, 2000, 1000, 500);
        check_val("rst_level", int'(bus.level), 0);
        check_val("rst_episodes", int'(bus.episodes), 0);
        step(1'b1, 1'b1, 2000, 1000, 500);
        step(1'b1, 1'b1, 2000, 1000, 500);
        check_val("rst_no_early_rise", int'(bus.rise), 0);
        step(1'b1, 1'b1, 2000, 1000, 500);
        check_val("rst_rise_third", int'(bus.rise), 1);

        // Clean episode from a fresh reset.
        step(1'b0, 1'b1, 0, 1000, 500);
        clean_x = '{1200, 1500, 1300, 800, 400, 300, 200};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, clean_x[i], 1000, 500);
            if (i == 2) begin
                check_val("clean_rise", int'(bus.rise), 1);
                check_val("clean_level", int'(bus.level), 1);
            end
        end
        check_val("clean_fall", int'(bus.fall), 1);
        check_val("clean_peak_valid", int'(bus.peak_valid), 1);
        check_val("clean_peak", int'(bus.peak), 1500);
        check_val("clean_episodes", int'(bus.episodes), 1);

        // Glitch rejection, then chatter around thr_lo while high.
        run_n(2, 1200);
        step(1'b1, 1'b1, 900, 1000, 500);
        check_val("glitch_level", int'(bus.level), 0);
        check_val("glitch_episodes", int'(bus.episodes), 1);
        run_n(3, 1200);
        chat_x = '{400, 400, 600, 400, 400, 400};
        falls = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, chat_x[i], 1000, 500);
            falls += int'(bus.fall);
        end
        check_val("chatter_fall_count", falls, 1);
        check_val("chatter_fall_last", int'(bus.fall), 1);

        // Disabled samples are ignored.
        step(1'b1, 1'b1, 1200, 1000, 500);
        step(1'b1, 1'b0, 0, 1000, 500);
        step(1'b1, 1'b0, 0, 1000, 500);
        step(1'b1, 1'b1, 1200, 1000, 500);
        step(1'b1, 1'b1, 1200, 1000, 500);
        check_val("en_gate_rise", int'(bus.rise), 1);

        // Reset while arming low with a tracked peak of 1500.
        step(1'b1, 1'b1, 1500, 1000, 500);
        step(1'b1, 1'b1, 400, 1000, 500);
        step(1'b0, 1'b1, 400, 1000, 500);
        check_val("rst_mid_fall", int'(bus.fall), 0);
        check_val("rst_mid_peak", int'(bus.peak), 0);
        check_val("rst_mid_level", int'(bus.level), 0);

        // Configuration error while high.
        run_n(3, 1200);
        step(1'b1, 1'b1, 400, 500, 500);
        check_val("cfg_err_set", int'(bus.cfg_err), 1);
        check_val("cfg_err_level", int'(bus.level), 0);
        step(1'b1, 1'b1, 400, 500, 500);
        check_val("cfg_err_no_fall", int'(bus.fall), 0);
        step(1'b1, 1'b1, 400, 1000, 500);
        check_val("cfg_err_clear", int'(bus.cfg_err), 0);

        // Randomized traffic with sticky signal regions so dwell runs actually form.
        region = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) region = int'($urandom_range(0, 2));
            case (region)
                0:       xv = int'($urandom_range(0, 800)) - 300;
                1:       xv = int'($urandom_range(0, 498)) + 501;
                default: xv = int'($urandom_range(0, 1200)) + 1000;
            endcase
            hv = 1000;
            lv = 500;
            if ($urandom_range(0, 49) == 0) begin
                hv = 500;
            end else if ($urandom_range(0, 9) == 0) begin
                hv = int'($urandom_range(0, 400)) + 800;
                lv = int'($urandom_range(0, 400)) + 300;
            end
            ev = ($urandom_range(0, 99) < 85);
            rv = ($urandom_range(0, 199) != 0);
            step(rv, ev, xv, hv, lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
